// File: rtl/fma_dot_accum.sv
// Dot-product sequencer around an external combinational FMA_32: operands are registered, results are folded into acc.
// Optional macro DOT_ACC_SPECIAL_EN enables NaN/Inf operand flagging with forced quiet-NaN output.
module fma_dot_accum #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  input  logic [31:0]      init_c,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [31:0]      fma_c,
  input  logic [31:0]      fma_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [LEN_W-1:0] out_count,
  output logic             out_special,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [31:0]      acc_q, acc_d;
  logic             op_vld_q, op_vld_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             accept;
  logic             out_hs;

  assign in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  assign fma_a     = op_a_q;
  assign fma_b     = op_b_q;
  assign fma_c     = acc_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACC;
      ACC:     if (accept && in_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    count_d  = count_q;
    op_vld_d = accept;
    if (accept) begin
      op_a_d = in_a;
      op_b_d = in_b;
      if (state_q == IDLE) begin
        count_d = LEN_W'(1);
      end else if (count_q != {LEN_W{1'b1}}) begin
        count_d = count_q + LEN_W'(1);
      end
    end
    // The first pair of a vector seeds acc; a product issued last cycle folds in otherwise.
    if (accept && (state_q == IDLE)) begin
      acc_d = init_c;
    end else if (op_vld_q) begin
      acc_d = fma_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      op_vld_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      op_vld_q <= op_vld_d;
      count_q  <= count_d;
    end
  end

`ifdef DOT_ACC_SPECIAL_EN
  logic special_q, special_d;
  logic in_is_special;

  assign in_is_special = (in_a[30:23] == 8'hFF) || (in_b[30:23] == 8'hFF) ||
                         ((state_q == IDLE) && (init_c[30:23] == 8'hFF));

  always_comb begin
    special_d = special_q;
    if (out_hs) begin
      special_d = 1'b0;
    end else if (accept && in_is_special) begin
      special_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) special_q <= 1'b0;
    else        special_q <= special_d;
  end

  assign out_special = special_q;
  assign out_data    = (special_q && (state_q == DONE)) ? 32'h7FC00000 : acc_q;
`else
  logic unused_hs;
  assign unused_hs   = out_hs;
  assign out_special = 1'b0;
  assign out_data    = acc_q;
`endif

endmodule
